rob_multi: RTL and testbench

- Parametrised reorder buffer, the successor to the fixed 32-entry, 3-wide ROB.
- Sits between rename/dispatch (allocation), the execution units (write-back) and the architectural RAT/free list (commit/retire).
- Adds the following over the fixed ROB:
  - partial-group allocation with per-lane valid;
  - a configurable number of write-back ports;
  - occupancy-count based full/empty;
  - precise in-order exception reporting that halts commit at the faulting entry.

---
 rtl/rob_pkg.sv | 12 +
 rtl/rob_commit_sel.sv | 28 ++
 rtl/rob_multi.sv | 136 +++++++++++++
 tb/tb_rob_multi.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: shared defaults and tag-width helper for the reorder buffer
package rob_pkg;
    localparam int ROB_DEPTH = 32;
    localparam int ROB_IW    = 3;
    localparam int ROB_WB    = 2;
    localparam int ROB_AW    = 3;
    localparam int ROB_PW    = 5;

    function automatic int tag_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/rob_commit_sel.sv
// rob_commit_sel: in-order commit prefix and exception detect over the head window
module rob_commit_sel import rob_pkg::*; #(
    parameter  int IW = ROB_IW,
    parameter  int TW = 5,
    localparam int CW = $clog2(IW + 1)
) (
    input  logic [IW-1:0] valid,
    input  logic [IW-1:0] done,
    input  logic [IW-1:0] exp,
    input  logic [TW:0]   count,
    output logic [IW-1:0] mask,
    output logic [CW-1:0] n,
    output logic          exp_valid
);
    logic run;

    always_comb begin
        run  = 1'b1;
        mask = '0;
        n    = '0;
        for (int i = 0; i < IW; i++) begin
            run     = run && (i < int'(count)) && valid[i] && done[i] && !exp[i];
            mask[i] = run;
            n       = n + CW'(run);
        end
        exp_valid = valid[0] && done[0] && exp[0];
    end
endmodule

// File: rtl/rob_multi.sv
// rob_multi: parametrised reorder buffer with partial-group allocation,
// multi-port write-back, occupancy-based full/empty and precise exceptions
module rob_multi import rob_pkg::*; #(
    parameter  int DEPTH = ROB_DEPTH,
    parameter  int IW    = ROB_IW,
    parameter  int WB    = ROB_WB,
    parameter  int AW    = ROB_AW,
    parameter  int PW    = ROB_PW,
    localparam int TW    = tag_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             freeze_front,
    input  logic             freeze_back,
    input  logic [IW-1:0]    alloc_valid,
    input  logic [IW*AW-1:0] alloc_rw,
    input  logic [IW*PW-1:0] alloc_pw_old,
    output logic             alloc_ready,
    output logic [IW*TW-1:0] alloc_tag,
    input  logic [WB-1:0]    wb_valid,
    input  logic [WB*TW-1:0] wb_tag,
    input  logic [WB*PW-1:0] wb_pw,
    input  logic [WB-1:0]    wb_exp,
    output logic [IW-1:0]    commit_valid,
    output logic [IW*AW-1:0] commit_rw,
    output logic [IW*PW-1:0] commit_pw,
    output logic [IW*PW-1:0] commit_pw_old,
    output logic             exp_valid,
    output logic [TW-1:0]    exp_tag,
    output logic [TW:0]      count,
    output logic             empty
);
    localparam int CW = $clog2(IW + 1);

    typedef struct packed {
        logic          valid;
        logic          done;
        logic          exp;
        logic [AW-1:0] rw;
        logic [PW-1:0] pw;
        logic [PW-1:0] pw_old;
    } rob_entry_t;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rob_multi: DEPTH must be a power of two and at least 4");
    end

    rob_entry_t    ent [DEPTH];
    logic [TW-1:0] head, tail;
    logic [TW:0]   cnt;
    logic [IW-1:0] h_valid, h_done, h_exp, c_mask;
    logic [CW-1:0] n_alloc, n_add, n_commit;
    logic          run_a, alloc_fire;

    always_comb begin
        run_a   = 1'b1;
        n_alloc = '0;
        for (int i = 0; i < IW; i++) begin
            run_a   = run_a && alloc_valid[i];
            n_alloc = n_alloc + CW'(run_a);
            h_valid[i] = ent[head + TW'(i)].valid;
            h_done[i]  = ent[head + TW'(i)].done;
            h_exp[i]   = ent[head + TW'(i)].exp;
            alloc_tag[i*TW +: TW]     = tail + TW'(i);
            commit_rw[i*AW +: AW]     = ent[head + TW'(i)].rw;
            commit_pw[i*PW +: PW]     = ent[head + TW'(i)].pw;
            commit_pw_old[i*PW +: PW] = ent[head + TW'(i)].pw_old;
        end
    end

    // readiness looks only at registered occupancy, never at this cycle's commit
    assign alloc_ready  = cnt <= (TW+1)'(DEPTH - IW);
    assign alloc_fire   = !freeze_front && alloc_ready;
    assign n_add        = alloc_fire ? n_alloc : '0;
    assign commit_valid = c_mask;
    assign exp_tag      = head;
    assign count        = cnt;
    assign empty        = cnt == '0;

    rob_commit_sel #(.IW(IW), .TW(TW)) u_sel (
        .valid     (h_valid),
        .done      (h_done),
        .exp       (h_exp),
        .count     (cnt),
        .mask      (c_mask),
        .n         (n_commit),
        .exp_valid (exp_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].valid <= 1'b0;
                ent[i].done  <= 1'b0;
                ent[i].exp   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < IW; i++) begin
                if (c_mask[i]) begin
                    ent[head + TW'(i)].valid <= 1'b0;
                    ent[head + TW'(i)].done  <= 1'b0;
                end
            end
            // highest port first so the lowest index lands last and wins
            for (int p = WB - 1; p >= 0; p--) begin
                if (!freeze_back && wb_valid[p] && ent[wb_tag[p*TW +: TW]].valid
                    && !ent[wb_tag[p*TW +: TW]].done) begin
                    ent[wb_tag[p*TW +: TW]].done <= 1'b1;
                    ent[wb_tag[p*TW +: TW]].exp  <= wb_exp[p];
                    ent[wb_tag[p*TW +: TW]].pw   <= wb_pw[p*PW +: PW];
                end
            end
            for (int i = 0; i < IW; i++) begin
                if (CW'(i) < n_add) begin
                    ent[tail + TW'(i)].valid  <= 1'b1;
                    ent[tail + TW'(i)].done   <= 1'b0;
                    ent[tail + TW'(i)].exp    <= 1'b0;
                    ent[tail + TW'(i)].rw     <= alloc_rw[i*AW +: AW];
                    ent[tail + TW'(i)].pw_old <= alloc_pw_old[i*PW +: PW];
                end
            end
            head <= head + TW'(n_commit);
            tail <= tail + TW'(n_add);
            cnt  <= cnt + (TW+1)'(n_add) - (TW+1)'(n_commit);
        end
    end
endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: directed scenarios plus randomized traffic against a queue model
module tb_rob_multi;
    localparam int DEPTH = 32, IW = 3, WB = 2, AW = 3, PW = 5, TW = 5;

    logic             clk = 1'b0, rst, flush, freeze_front, freeze_back;
    logic [IW-1:0]    alloc_valid;
    logic [IW*AW-1:0] alloc_rw;
    logic [IW*PW-1:0] alloc_pw_old;
    logic             alloc_ready;
    logic [IW*TW-1:0] alloc_tag;
    logic [WB-1:0]    wb_valid, wb_exp;
    logic [WB*TW-1:0] wb_tag;
    logic [WB*PW-1:0] wb_pw;
    logic [IW-1:0]    commit_valid;
    logic [IW*AW-1:0] commit_rw;
    logic [IW*PW-1:0] commit_pw, commit_pw_old;
    logic             exp_valid, empty;
    logic [TW-1:0]    exp_tag;
    logic [TW:0]      count;

    rob_multi #(.DEPTH(DEPTH), .IW(IW), .WB(WB), .AW(AW), .PW(PW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze_front(freeze_front), .freeze_back(freeze_back),
        .alloc_valid(alloc_valid), .alloc_rw(alloc_rw), .alloc_pw_old(alloc_pw_old),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_pw(wb_pw), .wb_exp(wb_exp),
        .commit_valid(commit_valid), .commit_rw(commit_rw), .commit_pw(commit_pw),
        .commit_pw_old(commit_pw_old), .exp_valid(exp_valid), .exp_tag(exp_tag),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // model: in-flight entries oldest first; tag of q[k] is (m_head+k) mod DEPTH
    typedef struct {
        logic          done;
        logic          exp;
        logic [AW-1:0] rw;
        logic [PW-1:0] pw;
        logic [PW-1:0] pwo;
    } me_t;
    me_t q[$];
    int  m_head, m_tail, n_chk, n_pass;

    function automatic int m_ncommit();
        int k = 0;
        while (k < IW && k < q.size() && q[k].done && !q[k].exp) k++;
        return k;
    endfunction

    function automatic logic [IW-1:0] m_mask();
        logic [IW-1:0] r = '0;
        for (int i = 0; i < m_ncommit(); i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic m_ready();
        return (DEPTH - q.size()) >= IW;
    endfunction

    function automatic logic m_expv();
        return q.size() > 0 && q[0].done && q[0].exp;
    endfunction

    function automatic logic [IW*TW-1:0] m_atag();
        logic [IW*TW-1:0] r;
        for (int i = 0; i < IW; i++) r[i*TW +: TW] = TW'((m_tail + i) % DEPTH);
        return r;
    endfunction

    task automatic idle();
        flush = 0; freeze_front = 0; freeze_back = 0;
        alloc_valid = '0; alloc_rw = '0; alloc_pw_old = '0;
        wb_valid = '0; wb_tag = '0; wb_pw = '0; wb_exp = '0;
    endtask

    task automatic alloc_grp(input logic [IW-1:0] v);
        alloc_valid  = v;
        alloc_rw     = (IW*AW)'($urandom);
        alloc_pw_old = (IW*PW)'($urandom);
    endtask

    task automatic set_wb(input int p, input int tag, input int pw, input logic ex);
        wb_valid[p] = 1'b1;
        wb_tag[p*TW +: TW] = TW'(tag);
        wb_pw[p*PW +: PW] = PW'(pw);
        wb_exp[p] = ex;
    endtask

    // advance one clock edge and apply the same inputs to the model
    task automatic tick();
        int k, n, pos;
        logic rdy, run;
        me_t e;
        @(posedge clk);
        k = m_ncommit();
        rdy = m_ready();
        if (flush) begin
            q.delete(); m_head = 0; m_tail = 0;
        end else begin
            if (!freeze_back) for (int p = 0; p < WB; p++) if (wb_valid[p]) begin
                pos = (int'(wb_tag[p*TW +: TW]) - m_head + DEPTH) % DEPTH;
                if (pos < q.size() && !q[pos].done) begin
                    e = q[pos]; e.done = 1; e.exp = wb_exp[p]; e.pw = wb_pw[p*PW +: PW]; q[pos] = e;
                end
            end
            for (int i = 0; i < k; i++) void'(q.pop_front());
            m_head = (m_head + k) % DEPTH;
            n = 0; run = 1;
            if (!freeze_front && rdy) for (int i = 0; i < IW; i++) begin
                run = run && alloc_valid[i];
                if (run) begin
                    e.done = 0; e.exp = 0; e.pw = '0;
                    e.rw = alloc_rw[i*AW +: AW]; e.pwo = alloc_pw_old[i*PW +: PW];
                    q.push_back(e); n++;
                end
            end
            m_tail = (m_tail + n) % DEPTH;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 0; idle();
        q.delete(); m_head = 0; m_tail = 0;
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic fill_groups(input int g);
        for (int i = 0; i < g; i++) begin idle(); alloc_grp(3'b111); @(negedge clk); tick(); end
    endtask

    task automatic test_reset();
        idle(); rst = 0;
        @(negedge clk);
        n_chk++; if (count !== 6'd0 || empty !== 1'b1) $display("FAIL reset_count: got %0d/%b want 0/1", count, empty); else n_pass++;
        n_chk++; if (alloc_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", alloc_ready); else n_pass++;
        n_chk++; if (alloc_tag !== {5'd2, 5'd1, 5'd0}) $display("FAIL reset_tag: got %h want %h", alloc_tag, {5'd2, 5'd1, 5'd0}); else n_pass++;
        n_chk++; if (commit_valid !== 3'b000 || exp_valid !== 1'b0) $display("FAIL reset_commit: got %b/%b want 000/0", commit_valid, exp_valid); else n_pass++;
        rst = 1; @(posedge clk); #1;
        alloc_grp(3'b111); @(negedge clk); tick(); idle();
        #2 rst = 0; #1;
        n_chk++; if (count !== 6'd0 || empty !== 1'b1) $display("FAIL reset_async: got %0d/%b want 0/1", count, empty); else n_pass++;
        q.delete(); m_head = 0; m_tail = 0;
        @(negedge clk); rst = 1; @(posedge clk); #1;
    endtask

    task automatic test_alloc_basic();
        logic [IW*TW-1:0] w;
        for (int g = 0; g < 3; g++) begin
            idle(); alloc_grp(3'b111);
            for (int i = 0; i < IW; i++) w[i*TW +: TW] = TW'(3*g + i);
            @(negedge clk);
            n_chk++; if (alloc_tag !== w) $display("FAIL alloc_tag g%0d: got %h want %h", g, alloc_tag, w); else n_pass++;
            tick();
        end
        idle(); @(negedge clk);
        n_chk++; if (count !== 6'd9) $display("FAIL alloc_count: got %0d want 9", count); else n_pass++;
        n_chk++; if (commit_valid !== 3'b000 || alloc_ready !== 1'b1) $display("FAIL alloc_state: got %b/%b want 000/1", commit_valid, alloc_ready); else n_pass++;
        tick();
    endtask

    task automatic test_wb_order();
        int seq[4] = '{2, 0, 1, -1};
        logic [IW-1:0] want[4] = '{3'b000, 3'b000, 3'b001, 3'b011};
        for (int c = 0; c < 4; c++) begin
            idle(); if (seq[c] >= 0) set_wb(0, seq[c], 11 + c, 0);
            @(negedge clk);
            n_chk++; if (commit_valid !== want[c]) $display("FAIL wb_order c%0d: got %b want %b", c, commit_valid, want[c]); else n_pass++;
            tick();
        end
        idle(); @(negedge clk);
        n_chk++; if (count !== 6'd6 || commit_valid !== 3'b000) $display("FAIL wb_order_end: got %0d/%b want 6/000", count, commit_valid); else n_pass++;
        n_chk++; if (alloc_tag[TW-1:0] !== 5'd9) $display("FAIL wb_order_tail: got %0d want 9", alloc_tag[TW-1:0]); else n_pass++;
        tick();
    endtask

    task automatic test_full();
        do_reset(); fill_groups(10);
        idle(); alloc_grp(3'b111); set_wb(0, 0, 7, 0);
        @(negedge clk);
        n_chk++; if (alloc_ready !== 1'b0 || count !== 6'd30) $display("FAIL full_ready: got %b/%0d want 0/30", alloc_ready, count); else n_pass++;
        tick();
        idle(); alloc_grp(3'b111); @(negedge clk);
        n_chk++; if (commit_valid !== 3'b001 || count !== 6'd30) $display("FAIL full_commit: got %b/%0d want 001/30", commit_valid, count); else n_pass++;
        n_chk++; if (alloc_ready !== 1'b0) $display("FAIL full_ready_hold: got %b want 0", alloc_ready); else n_pass++;
        tick();
        idle(); @(negedge clk);
        n_chk++; if (alloc_ready !== 1'b1 || count !== 6'd29) $display("FAIL full_release: got %b/%0d want 1/29", alloc_ready, count); else n_pass++;
        tick();
    endtask

    task automatic test_wrap();
        logic [IW-1:0] want[3] = '{3'b000, 3'b011, 3'b001};
        do_reset(); fill_groups(10);
        for (int c = 0; c < 15; c++) begin
            idle(); set_wb(0, 2*c, c, 0); set_wb(1, 2*c + 1, c + 1, 0);
            @(negedge clk);
            n_chk++; if (commit_valid !== m_mask()) $display("FAIL wrap_drain c%0d: got %b want %b", c, commit_valid, m_mask()); else n_pass++;
            tick();
        end
        for (int c = 0; c < 20 && q.size() > 0; c++) begin idle(); @(negedge clk); tick(); end
        idle(); alloc_grp(3'b111); @(negedge clk);
        n_chk++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty); else n_pass++;
        n_chk++; if (alloc_tag !== {5'd0, 5'd31, 5'd30}) $display("FAIL wrap_tag: got %h want %h", alloc_tag, {5'd0, 5'd31, 5'd30}); else n_pass++;
        tick();
        for (int c = 0; c < 3; c++) begin
            idle();
            if (c == 0) begin set_wb(0, 30, 1, 0); set_wb(1, 31, 2, 0); end
            if (c == 1) set_wb(0, 0, 3, 0);
            @(negedge clk);
            n_chk++; if (commit_valid !== want[c]) $display("FAIL wrap_commit c%0d: got %b want %b", c, commit_valid, want[c]); else n_pass++;
            tick();
        end
        idle(); @(negedge clk);
        n_chk++; if (count !== 6'd0 || empty !== 1'b1 || alloc_tag[TW-1:0] !== 5'd1) $display("FAIL wrap_end: got %0d/%b/%0d want 0/1/1", count, empty, alloc_tag[TW-1:0]); else n_pass++;
        tick();
    endtask

    task automatic test_exception();
        int wt0[8] = '{0, 2, 4, 6, -1, -1, -1, -1};
        int wt1[8] = '{1, 3, 5, -1, -1, -1, -1, -1};
        logic [IW-1:0] wc[8] = '{3'b000, 3'b011, 3'b011, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        logic we[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        do_reset(); fill_groups(3);
        for (int c = 0; c < 8; c++) begin
            idle();
            if (wt0[c] >= 0) set_wb(0, wt0[c], c, 0);
            if (wt1[c] >= 0) set_wb(1, wt1[c], c + 8, c == 2);
            flush = (c == 7);
            @(negedge clk);
            n_chk++; if (commit_valid !== wc[c]) $display("FAIL exc_commit c%0d: got %b want %b", c, commit_valid, wc[c]); else n_pass++;
            n_chk++; if (exp_valid !== we[c]) $display("FAIL exc_valid c%0d: got %b want %b", c, exp_valid, we[c]); else n_pass++;
            if (we[c]) begin
                n_chk++; if (exp_tag !== 5'd5) $display("FAIL exc_tag c%0d: got %0d want 5", c, exp_tag); else n_pass++;
            end
            tick();
        end
        idle(); @(negedge clk);
        n_chk++; if (count !== 6'd0 || exp_valid !== 1'b0 || alloc_tag[TW-1:0] !== 5'd0) $display("FAIL exc_flush: got %0d/%b/%0d want 0/0/0", count, exp_valid, alloc_tag[TW-1:0]); else n_pass++;
        tick();
    endtask

    task automatic test_wb_collide();
        int pa[4] = '{0, 2, 4, 6};
        int pb[4] = '{1, 3, 5, 8};
        logic seen7 = 0;
        do_reset(); fill_groups(3);
        idle(); set_wb(0, 7, 10, 0); set_wb(1, 7, 20, 0); @(negedge clk); tick();
        idle(); set_wb(0, 20, 3, 1); set_wb(1, 31, 4, 1); @(negedge clk); tick();
        for (int c = 0; c < 12 && q.size() > 0; c++) begin
            idle(); if (c < 4) begin set_wb(0, pa[c], c, 0); set_wb(1, pb[c], c, 0); end
            @(negedge clk);
            for (int i = 0; i < IW; i++) if (commit_valid[i] && (m_head + i) % DEPTH == 7) begin
                seen7 = 1;
                n_chk++; if (commit_pw[i*PW +: PW] !== 5'd10) $display("FAIL collide_pw: got %0d want 10", commit_pw[i*PW +: PW]); else n_pass++;
            end
            tick();
        end
        n_chk++; if (!seen7) $display("FAIL collide_seen: tag 7 commit got 0 want 1"); else n_pass++;
        idle(); @(negedge clk);
        n_chk++; if (count !== 6'd0 || exp_valid !== 1'b0) $display("FAIL collide_stray: got %0d/%b want 0/0", count, exp_valid); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int tg;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle(); alloc_grp(IW'($urandom));
            freeze_front = ($urandom_range(0, 7) == 0);
            freeze_back  = ($urandom_range(0, 7) == 0);
            for (int p = 0; p < WB; p++) if ($urandom_range(0, 2) != 0) begin
                tg = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                     (m_head + int'($urandom_range(0, q.size() - 1))) % DEPTH : int'($urandom_range(0, DEPTH - 1));
                set_wb(p, tg, int'($urandom_range(0, 31)), $urandom_range(0, 39) == 0);
            end
            flush = m_expv() ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
            @(negedge clk);
            n_chk++; if (commit_valid !== m_mask()) $display("FAIL rnd_commit c%0d: got %b want %b", c, commit_valid, m_mask()); else n_pass++;
            for (int i = 0; i < m_ncommit(); i++) begin
                n_chk++;
                if ({commit_rw[i*AW +: AW], commit_pw[i*PW +: PW], commit_pw_old[i*PW +: PW]} !== {q[i].rw, q[i].pw, q[i].pwo})
                    $display("FAIL rnd_payload c%0d l%0d: got %h/%h/%h want %h/%h/%h", c, i, commit_rw[i*AW +: AW],
                             commit_pw[i*PW +: PW], commit_pw_old[i*PW +: PW], q[i].rw, q[i].pw, q[i].pwo);
                else n_pass++;
            end
            n_chk++; if (count !== (TW+1)'(q.size()) || empty !== (q.size() == 0)) $display("FAIL rnd_count c%0d: got %0d/%b want %0d", c, count, empty, q.size()); else n_pass++;
            n_chk++; if (alloc_ready !== m_ready()) $display("FAIL rnd_ready c%0d: got %b want %b", c, alloc_ready, m_ready()); else n_pass++;
            n_chk++; if (alloc_tag !== m_atag()) $display("FAIL rnd_tag c%0d: got %h want %h", c, alloc_tag, m_atag()); else n_pass++;
            n_chk++; if (exp_valid !== m_expv()) $display("FAIL rnd_exp c%0d: got %b want %b", c, exp_valid, m_expv()); else n_pass++;
            if (m_expv()) begin
                n_chk++; if (exp_tag !== TW'(m_head)) $display("FAIL rnd_exp_tag c%0d: got %0d want %0d", c, exp_tag, m_head); else n_pass++;
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_pass = 0; m_head = 0; m_tail = 0;
        rst = 0; idle();
        test_reset();
        test_alloc_basic();
        test_wb_order();
        test_full();
        test_wrap();
        test_exception();
        test_wb_collide();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
